bsr_scan_engine: RTL and testbench

//  Parametrised boundary-scan chain with a built-in, sysclk-domain shift engine. Replaces hand-chained

---
 rtl/bsr_scan_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_bsr_scan_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_scan_engine.sv
// Parametrised boundary-scan chain with a sysclk-domain capture/shift/update command engine.
// Optional expected-value compare of shifted-out bits is enabled by defining BSR_SCAN_CHECK_EN.
module bsr_scan_engine #(
    parameter int unsigned NUM_SEG = 4,
    parameter int unsigned SEG_W   = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned LEN_W   = $clog2(DW + 1)
) (
    input  logic                     sysclk_i,
    input  logic                     sys_reset_i,
    input  logic                     mode_i,
    input  logic [NUM_SEG-1:0]       seg_en_i,
    input  logic [NUM_SEG*SEG_W-1:0] par_in_i,
    output logic [NUM_SEG*SEG_W-1:0] par_out_o,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [LEN_W-1:0]         cmd_len_i,
    input  logic [DW-1:0]            cmd_data_i,
    input  logic [DW-1:0]            cmd_expect_i,
    input  logic [DW-1:0]            cmd_mask_i,
    output logic                     rsp_valid_o,
    output logic [DW-1:0]            rsp_data_o,
    output logic                     rsp_mismatch_o
);

    localparam int unsigned CW    = NUM_SEG * SEG_W;
    localparam int unsigned IDX_W = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] OP_CAPTURE = 2'b00;
    localparam logic [1:0] OP_CSU     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      sr_q, sr_d;
    logic [NUM_SEG-1:0] byp_q, byp_d;
    logic [CW-1:0]      upd_q, upd_d;
    logic [NUM_SEG-1:0] seg_en_q, seg_en_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DW-1:0]      data_q, data_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      cap_q, cap_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic               accept_c;
    logic [LEN_W-1:0]   len_clamp_c;
    logic               si_c;
    logic               so_c;
    logic [NUM_SEG-1:0] seg_out_c;
    logic [NUM_SEG-1:0] seg_in_c;

    // Next step of the command sequence; steps not named by the opcode are skipped.
    function automatic state_t step_after(input state_t cur, input logic [1:0] op,
                                          input logic [LEN_W-1:0] len);
        logic do_cap;
        logic do_shift;
        logic do_upd;
        state_t nxt;
        do_cap   = (op == OP_CAPTURE) || (op == OP_CSU);
        do_shift = op[0] && (len != '0);
        do_upd   = op[1];
        nxt      = ST_RESP;
        case (cur)
            ST_IDLE: begin
                if (do_cap)        nxt = ST_CAPTURE;
                else if (do_shift) nxt = ST_SHIFT;
                else if (do_upd)   nxt = ST_UPDATE;
            end
            ST_CAPTURE: begin
                if (do_shift)      nxt = ST_SHIFT;
                else if (do_upd)   nxt = ST_UPDATE;
            end
            ST_SHIFT: begin
                if (do_upd)        nxt = ST_UPDATE;
            end
            default: nxt = ST_RESP;
        endcase
        return nxt;
    endfunction

    assign accept_c    = cmd_valid_i && (state_q == ST_IDLE);
    assign len_clamp_c = (cmd_len_i > LEN_W'(DW)) ? LEN_W'(DW) : cmd_len_i;
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign par_out_o   = mode_i ? upd_q : par_in_i;

    // Chain taps: a disabled segment is represented by its single bypass flop.
    always_comb begin
        seg_out_c = '0;
        for (int unsigned k = 0; k < NUM_SEG; k++) begin
            seg_out_c[k] = seg_en_q[k] ? sr_q[k*SEG_W] : byp_q[k];
        end
    end

    assign si_c = data_q[cnt_q[IDX_W-1:0]];
    assign so_c = seg_out_c[0];

    always_comb begin
        seg_in_c            = '0;
        seg_in_c[NUM_SEG-1] = si_c;
        for (int unsigned k = 0; k + 1 < NUM_SEG; k++) begin
            seg_in_c[k] = seg_out_c[k+1];
        end
    end

    // Command sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) state_d = step_after(ST_IDLE, cmd_op_i, len_clamp_c);
            end
            ST_CAPTURE: state_d = step_after(ST_CAPTURE, op_q, len_q);
            ST_SHIFT: begin
                if (cnt_q == len_q - LEN_W'(1)) state_d = step_after(ST_SHIFT, op_q, len_q);
            end
            ST_UPDATE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Chain, command latch and response datapath.
    always_comb begin
        logic [SEG_W-1:0] seg_next;
        sr_d        = sr_q;
        byp_d       = byp_q;
        upd_d       = upd_q;
        seg_en_d    = seg_en_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = (state_q == ST_RESP);
        seg_next    = '0;

        if (accept_c) begin
            seg_en_d = seg_en_i;
            op_d     = cmd_op_i;
            len_d    = len_clamp_c;
            data_d   = cmd_data_i;
            cnt_d    = '0;
            cap_d    = '0;
        end

        case (state_q)
            ST_CAPTURE: begin
                for (int unsigned k = 0; k < NUM_SEG; k++) begin
                    if (seg_en_q[k]) sr_d[k*SEG_W +: SEG_W] = par_in_i[k*SEG_W +: SEG_W];
                end
                byp_d = '0;
            end
            ST_SHIFT: begin
                for (int unsigned k = 0; k < NUM_SEG; k++) begin
                    if (seg_en_q[k]) begin
                        seg_next              = sr_q[k*SEG_W +: SEG_W] >> 1;
                        seg_next[SEG_W-1]     = seg_in_c[k];
                        sr_d[k*SEG_W +: SEG_W] = seg_next;
                    end else begin
                        byp_d[k] = seg_in_c[k];
                    end
                end
                cap_d[cnt_q[IDX_W-1:0]] = so_c;
                cnt_d                   = cnt_q + LEN_W'(1);
            end
            ST_UPDATE: begin
                for (int unsigned k = 0; k < NUM_SEG; k++) begin
                    if (seg_en_q[k]) upd_d[k*SEG_W +: SEG_W] = sr_q[k*SEG_W +: SEG_W];
                end
            end
            ST_RESP: rsp_data_d = cap_q;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (sys_reset_i) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            byp_q       <= '0;
            upd_q       <= '0;
            seg_en_q    <= '0;
            op_q        <= '0;
            len_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            byp_q       <= byp_d;
            upd_q       <= upd_d;
            seg_en_q    <= seg_en_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef BSR_SCAN_CHECK_EN
    logic [DW-1:0] exp_q, exp_d;
    logic [DW-1:0] mask_q, mask_d;
    logic [DW-1:0] len_mask_c;
    logic          rsp_mm_q, rsp_mm_d;

    // Only the bits actually shifted out take part in the compare.
    assign len_mask_c = (len_q >= LEN_W'(DW)) ? '1 : ((DW'(1) << len_q) - DW'(1));

    always_comb begin
        exp_d    = exp_q;
        mask_d   = mask_q;
        rsp_mm_d = rsp_mm_q;
        if (accept_c) begin
            exp_d  = cmd_expect_i;
            mask_d = cmd_mask_i;
        end
        if (state_q == ST_RESP) rsp_mm_d = |((cap_q ^ exp_q) & mask_q & len_mask_c);
    end

    always_ff @(posedge sysclk_i) begin
        if (sys_reset_i) begin
            exp_q    <= '0;
            mask_q   <= '0;
            rsp_mm_q <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            mask_q   <= mask_d;
            rsp_mm_q <= rsp_mm_d;
        end
    end

    assign rsp_mismatch_o = rsp_mm_q;
`else
    logic unused_check_c;
    assign unused_check_c = ^{cmd_expect_i, cmd_mask_i};
    assign rsp_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsr_scan_engine.sv
// Directed self-checking bench for bsr_scan_engine (NUM_SEG=4, SEG_W=8, DW=32).
module tb_bsr_scan_engine;

    logic        sysclk;
    logic        sys_reset;
    logic        mode;
    logic [3:0]  seg_en;
    logic [31:0] par_in;
    logic [31:0] par_out;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic [31:0] cmd_expect;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_mismatch;

    int checks;
    int failures;

    bsr_scan_engine #(.NUM_SEG(4), .SEG_W(8), .DW(32)) dut (
        .sysclk_i      (sysclk),
        .sys_reset_i   (sys_reset),
        .mode_i        (mode),
        .seg_en_i      (seg_en),
        .par_in_i      (par_in),
        .par_out_o     (par_out),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_len_i     (cmd_len),
        .cmd_data_i    (cmd_data),
        .cmd_expect_i  (cmd_expect),
        .cmd_mask_i    (cmd_mask),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .rsp_mismatch_o(rsp_mismatch)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
    endtask

    // Issue one command and return cycles from accept to rsp_valid (-1 on timeout).
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           input logic [31:0] expv, input logic [31:0] mask, output int lat);
        int waitc;
        cmd_op     = op;
        cmd_len    = len;
        cmd_data   = data;
        cmd_expect = expv;
        cmd_mask   = mask;
        cmd_valid  = 1'b1;
        waitc      = 0;
        while (!cmd_ready && waitc < 100) begin
            tick();
            waitc++;
        end
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rsp_valid && lat < 200);
        if (!rsp_valid) lat = -1;
    endtask

    task automatic test_reset();
        mode = 1'b1;
        do_reset();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (par_out !== 32'h0) begin failures++; $display("FAIL reset_par_out got=%h exp=00000000", par_out); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00000000", rsp_data); end
    endtask

    task automatic test_full_chain();
        int lat;
        logic exp_mm;
`ifdef BSR_SCAN_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        seg_en = 4'hF;
        par_in = 32'hA5C30F81;
        mode   = 1'b1;
        run_cmd(2'b11, 6'd32, 32'h12345678, 32'hA5C30F80, 32'h00000001, lat);
        checks++; if (lat !== 35) begin failures++; $display("FAIL full_latency got=%0d exp=35", lat); end
        checks++; if (rsp_data !== 32'hA5C30F81) begin failures++; $display("FAIL full_rsp_data got=%h exp=A5C30F81", rsp_data); end
        checks++; if (rsp_mismatch !== exp_mm) begin failures++; $display("FAIL full_mismatch_bit0 got=%b exp=%b", rsp_mismatch, exp_mm); end
        checks++; if (par_out !== 32'h12345678) begin failures++; $display("FAIL full_par_out_test got=%h exp=12345678", par_out); end
        mode = 1'b0;
        #1;
        checks++; if (par_out !== 32'hA5C30F81) begin failures++; $display("FAIL full_par_out_func got=%h exp=A5C30F81", par_out); end
        mode = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL full_rsp_pulse got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 32'hA5C30F81) begin failures++; $display("FAIL full_rsp_hold got=%h exp=A5C30F81", rsp_data); end
        run_cmd(2'b11, 6'd32, 32'h12345678, 32'hA5C30F80, 32'hFFFFFFFE, lat);
        checks++; if (rsp_mismatch !== 1'b0) begin failures++; $display("FAIL full_mismatch_masked got=%b exp=0", rsp_mismatch); end
    endtask

    task automatic test_zero_len();
        int lat;
        seg_en = 4'hF;
        run_cmd(2'b01, 6'd0, 32'hFFFFFFFF, 32'h0, 32'h0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL zero_rsp_data got=%h exp=00000000", rsp_data); end
        run_cmd(2'b01, 6'd32, 32'h00000000, 32'h0, 32'h0, lat);
        checks++; if (lat !== 33) begin failures++; $display("FAIL zero_verify_latency got=%0d exp=33", lat); end
        checks++; if (rsp_data !== 32'h12345678) begin failures++; $display("FAIL zero_chain_kept got=%h exp=12345678", rsp_data); end
        run_cmd(2'b01, 6'd40, 32'hDEADBEEF, 32'h0, 32'h0, lat);
        checks++; if (lat !== 33) begin failures++; $display("FAIL clamp_latency got=%0d exp=33", lat); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL clamp_rsp_data got=%h exp=00000000", rsp_data); end
        run_cmd(2'b01, 6'd32, 32'h00000000, 32'h0, 32'h0, lat);
        checks++; if (rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL clamp_chain got=%h exp=DEADBEEF", rsp_data); end
        checks++; if (par_out !== 32'h12345678) begin failures++; $display("FAIL shift_no_update got=%h exp=12345678", par_out); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic ready_seen;
        seg_en     = 4'hF;
        par_in     = 32'h0F1E2D3C;
        cmd_op     = 2'b11;
        cmd_len    = 6'd32;
        cmd_data   = 32'hCAFEF00D;
        cmd_expect = 32'h0;
        cmd_mask   = 32'h0;
        cmd_valid  = 1'b1;
        tick();
        cmd_op     = 2'b00;
        cmd_data   = 32'hFFFFFFFF;
        seg_en     = 4'h0;
        ready_seen = 1'b0;
        lat        = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            lat++;
            if (cmd_ready) ready_seen = 1'b1;
        end
        cmd_valid = 1'b0;
        checks++; if (ready_seen !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", ready_seen); end
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 35) begin failures++; $display("FAIL busy_latency got=%0d exp=35", lat); end
        checks++; if (rsp_data !== 32'h0F1E2D3C) begin failures++; $display("FAIL busy_rsp_data got=%h exp=0F1E2D3C", rsp_data); end
        checks++; if (par_out !== 32'hCAFEF00D) begin failures++; $display("FAIL busy_par_out got=%h exp=CAFEF00D", par_out); end
    endtask

    task automatic test_reset_midshift();
        logic stray;
        seg_en     = 4'hF;
        par_in     = 32'hA5C30F81;
        cmd_op     = 2'b11;
        cmd_len    = 6'd32;
        cmd_data   = 32'h12345678;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (par_out !== 32'h0) begin failures++; $display("FAIL abort_par_out got=%h exp=00000000", par_out); end
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=%b exp=0", stray); end
    endtask

    task automatic test_bypass_only();
        int lat;
        mode = 1'b1;
        do_reset();
        seg_en = 4'h0;
        par_in = 32'hFFFFFFFF;
        run_cmd(2'b01, 6'd8, 32'h000000F3, 32'h0, 32'h0, lat);
        checks++; if (lat !== 9) begin failures++; $display("FAIL bypass_latency got=%0d exp=9", lat); end
        checks++; if (rsp_data !== 32'h00000030) begin failures++; $display("FAIL bypass_rsp_data got=%h exp=00000030", rsp_data); end
        run_cmd(2'b10, 6'd0, 32'h0, 32'h0, 32'h0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL update_latency got=%0d exp=2", lat); end
        checks++; if (par_out !== 32'h0) begin failures++; $display("FAIL bypass_par_out got=%h exp=00000000", par_out); end
    endtask

    task automatic test_partial_chain();
        int lat;
        do_reset();
        seg_en = 4'b0001;
        par_in = 32'hFFFFFF81;
        run_cmd(2'b11, 6'd12, 32'h00000ABD, 32'h0, 32'h0, lat);
        checks++; if (lat !== 15) begin failures++; $display("FAIL partial_latency got=%0d exp=15", lat); end
        checks++; if (rsp_data !== 32'h00000881) begin failures++; $display("FAIL partial_rsp_data got=%h exp=00000881", rsp_data); end
        checks++; if (par_out !== 32'h0000005E) begin failures++; $display("FAIL partial_par_out got=%h exp=0000005E", par_out); end
    endtask

    task automatic test_back_to_back();
        int lat;
        seg_en = 4'hF;
        par_in = 32'h13572468;
        run_cmd(2'b00, 6'd0, 32'h0, 32'h0, 32'h0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_capture_latency got=%0d exp=2", lat); end
        run_cmd(2'b01, 6'd16, 32'h0000FFFF, 32'h0, 32'h0, lat);
        checks++; if (lat !== 17) begin failures++; $display("FAIL b2b_shift_latency got=%0d exp=17", lat); end
        checks++; if (rsp_data !== 32'h00002468) begin failures++; $display("FAIL b2b_low_half got=%h exp=00002468", rsp_data); end
        run_cmd(2'b01, 6'd16, 32'h00000000, 32'h0, 32'h0, lat);
        checks++; if (rsp_data !== 32'h00001357) begin failures++; $display("FAIL b2b_high_half got=%h exp=00001357", rsp_data); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        sys_reset  = 1'b0;
        mode       = 1'b1;
        seg_en     = 4'hF;
        par_in     = 32'h0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_len    = 6'd0;
        cmd_data   = 32'h0;
        cmd_expect = 32'h0;
        cmd_mask   = 32'h0;
        tick();
        test_reset();
        test_full_chain();
        test_zero_len();
        test_busy_ignore();
        test_reset_midshift();
        test_bypass_only();
        test_partial_chain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
